// File: rtl/instr_fetch_responder.sv
// ---------------------------------------------------------------------------
// instr_fetch_responder
//
// Instruction-memory responder for the fetch stage. A word address from the
// PC is accepted on a valid/ready handshake and looked up in a local store.
// The instruction is returned after a fixed latency on a second valid/ready
// handshake. Only one request is outstanding at a time (IDLE -> WAIT -> RESP).
//
// Latency: a request accepted at edge N has respValid sampled high by the
// consumer at edge N+LATENCY. The FSM enters RESP right after edge
// N+LATENCY-1.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   reqValid   in   fetch request present
//   reqAddr    in   fetch word address
//   reqReady   out  request can be accepted this cycle
//   flush      in   drop any in-flight or held fetch
//   respValid  out  response outputs valid
//   respReady  in   consumer takes the response (low = stall)
//   respAddr   out  address the response belongs to
//   respInstr  out  instruction word (NOP_WORD if out of range)
//   respErr    out  request address was >= DEPTH
//   loadEn     in   program-load write strobe (honoured in IDLE only)
//   loadAddr   in   program-load word address
//   loadData   in   program-load data
//   busy       out  FSM not in IDLE
// ---------------------------------------------------------------------------
module instr_fetch_responder #(
    parameter int          ADDR_W   = 32,
    parameter int          DEPTH    = 256,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    input  logic [ADDR_W-1:0] reqAddr,
    output logic              reqReady,
    input  logic              flush,
    output logic              respValid,
    input  logic              respReady,
    output logic [ADDR_W-1:0] respAddr,
    output logic [31:0]       respInstr,
    output logic              respErr,
    input  logic              loadEn,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [31:0]       loadData,
    output logic              busy
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        count_reg, count_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       instr_reg;
    logic              err_reg;

    logic [31:0]       mem [DEPTH];

    logic              enter_resp;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_in_range;
    logic              load_ok;

    // Loads and flushes both take priority over a new fetch in IDLE.
    assign reqReady  = reset && (state_reg == S_IDLE) && !loadEn && !flush;
    assign respValid = (state_reg == S_RESP);
    assign busy      = (state_reg != S_IDLE);
    assign respAddr  = addr_reg;
    assign respInstr = instr_reg;
    assign respErr   = err_reg;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        case (state_reg)
            S_IDLE: begin
                if (reqValid && reqReady) begin
                    addr_next  = reqAddr;
                    count_next = CNT_INIT;
                    state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // <= rather than == so a corrupted count can never stick here
                if (count_reg <= 4'd1) begin
                    state_next = S_RESP;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            S_RESP: begin
                if (respReady) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // A redirect discards whatever is in flight, including a response
        // being handed over in this same cycle (it still counts as taken).
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // The store is read exactly once per fetch, on the edge that enters RESP.
    // With LATENCY==1 that is the accept edge itself, so the address comes
    // straight from the request port instead of the latched copy.
    assign enter_resp  = (state_next == S_RESP) && (state_reg != S_RESP);
    assign rd_addr     = (state_reg == S_IDLE) ? reqAddr : addr_reg;
    assign rd_in_range = (rd_addr < DEPTH_A);   // full-width: no aliasing
    assign load_ok     = loadEn && (state_reg == S_IDLE) && (loadAddr < DEPTH_A);

    // ---------------- state and response registers ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            count_reg <= 4'd0;
            addr_reg  <= '0;
            instr_reg <= 32'h0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
            if (enter_resp) begin
                err_reg   <= !rd_in_range;
                instr_reg <= rd_in_range ? mem[rd_addr[IDX_W-1:0]] : NOP_WORD;
            end
        end
    end

    // ---------------- instruction store write port ----------------
    // Contents survive reset; writes are merely suppressed while it is held.
    always_ff @(posedge clock) begin
        if (reset && load_ok) begin
            mem[loadAddr[IDX_W-1:0]] <= loadData;
        end
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
module tb_instr_fetch_responder;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, flush, respReady, loadEn;
    logic [31:0] loadAddr, loadData, reqAddr;
    logic        reqValid, reqValid1, reqValid15;

    logic        reqReady, respValid, respErr, busy;
    logic [31:0] respAddr, respInstr;
    logic        reqReady1, respValid1, respErr1, busy1;
    logic [31:0] respAddr1, respInstr1;
    logic        reqReady15, respValid15, respErr15, busy15;
    logic [31:0] respAddr15, respInstr15;

    int checks = 0;
    int errors = 0;

    instr_fetch_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(2), .NOP_WORD(32'h0)) u_dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqAddr(reqAddr),
        .reqReady(reqReady), .flush(flush), .respValid(respValid), .respReady(respReady),
        .respAddr(respAddr), .respInstr(respInstr), .respErr(respErr), .loadEn(loadEn),
        .loadAddr(loadAddr), .loadData(loadData), .busy(busy)
    );

    instr_fetch_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(1), .NOP_WORD(32'h0)) u_dut1 (
        .clock(clock), .reset(reset), .reqValid(reqValid1), .reqAddr(reqAddr),
        .reqReady(reqReady1), .flush(flush), .respValid(respValid1), .respReady(respReady),
        .respAddr(respAddr1), .respInstr(respInstr1), .respErr(respErr1), .loadEn(loadEn),
        .loadAddr(loadAddr), .loadData(loadData), .busy(busy1)
    );

    instr_fetch_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(15), .NOP_WORD(32'h0)) u_dut15 (
        .clock(clock), .reset(reset), .reqValid(reqValid15), .reqAddr(reqAddr),
        .reqReady(reqReady15), .flush(flush), .respValid(respValid15), .respReady(respReady),
        .respAddr(respAddr15), .respInstr(respInstr15), .respErr(respErr15), .loadEn(loadEn),
        .loadAddr(loadAddr), .loadData(loadData), .busy(busy15)
    );

    // Present one request to the LATENCY=2 instance for exactly one edge.
    task automatic send_req(input logic [31:0] addr);
        @(negedge clock);
        reqValid = 1'b1;
        reqAddr  = addr;
        @(posedge clock);
        #1 reqValid = 1'b0;
    endtask

    // Count sampling edges after the accept edge until respValid is seen.
    task automatic wait_resp(input int max_cycles, output int lat);
        lat = -1;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clock);
            if (respValid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0; respReady = 1'b1; loadEn = 1'b0;
        loadAddr = 0; loadData = 0; reqAddr = 0;
        reqValid = 1'b1; reqValid1 = 1'b0; reqValid15 = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL reset_respValid: got %b expected 0", respValid); end
        checks++; if (respErr !== 1'b0) begin errors++; $display("FAIL reset_respErr: got %b expected 0", respErr); end
        checks++; if (respAddr !== 32'h0) begin errors++; $display("FAIL reset_respAddr: got %h expected 0", respAddr); end
        checks++; if (respInstr !== 32'h0) begin errors++; $display("FAIL reset_respInstr: got %h expected 0", respInstr); end
        checks++; if (busy !== 1'b0 || busy1 !== 1'b0 || busy15 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b%b expected 000", busy, busy1, busy15); end
        checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL reset_reqReady: got %b expected 0", reqReady); end
        reqValid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL post_reset_reqReady: got %b expected 1", reqReady); end
        $display("reset released");
    endtask

    task automatic test_load_store;
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            loadEn = 1'b1;
            if (i < 16) begin
                loadAddr = i;
                loadData = 32'hC0DE_0000 | i;
            end else if (i == 16) begin
                loadAddr = 44;
                loadData = 32'h4444_4444;
            end else begin
                loadAddr = 255;
                loadData = 32'hFF00_00FF;
            end
            reqValid = 1'b1;
            reqAddr  = 32'd1;
            #1;
            checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL load_blocks_req: got %b expected 0", reqReady); end
            $display("load addr=%0d data=%08h", loadAddr, loadData);
        end
        @(negedge clock);
        loadEn = 1'b0;
        reqValid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_no_accept: busy got %b expected 0", busy); end
    endtask

    task automatic test_latency_sweep;
        int lat;
        int exp_lat;
        logic [31:0] got_instr, got_addr;
        for (int s = 0; s < 2; s++) begin
            exp_lat = (s == 1) ? 15 : 1;
            for (int i = 0; i < 16; i++) begin
                @(negedge clock);
                reqAddr = i;
                if (s == 1) reqValid15 = 1'b1; else reqValid1 = 1'b1;
                #1;
                checks++; if (((s == 1) ? reqReady15 : reqReady1) !== 1'b1) begin errors++; $display("FAIL sweep_reqReady L%0d addr %0d: got 0 expected 1", exp_lat, i); end
                @(posedge clock);
                #1 reqValid1 = 1'b0; reqValid15 = 1'b0;
                lat = -1;
                for (int k = 1; k <= 40; k++) begin
                    @(negedge clock);
                    if (((s == 1) ? respValid15 : respValid1) === 1'b1) begin
                        lat = k;
                        break;
                    end
                end
                got_instr = (s == 1) ? respInstr15 : respInstr1;
                got_addr  = (s == 1) ? respAddr15 : respAddr1;
                checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sweep_latency L%0d addr %0d: got %0d expected %0d", exp_lat, i, lat, exp_lat); end
                checks++; if (got_instr !== (32'hC0DE_0000 | i)) begin errors++; $display("FAIL sweep_instr L%0d addr %0d: got %08h expected %08h", exp_lat, i, got_instr, 32'hC0DE_0000 | i); end
                checks++; if (got_addr !== i) begin errors++; $display("FAIL sweep_addr L%0d: got %0d expected %0d", exp_lat, got_addr, i); end
                $display("sweep L=%0d addr=%0d lat=%0d instr=%08h", exp_lat, i, lat, got_instr);
            end
        end
    endtask

    task automatic test_basic;
        int lat;
        @(negedge clock);
        loadEn = 1'b1; loadAddr = 3; loadData = 32'h2008_0005;
        @(negedge clock);
        loadEn = 1'b0; reqValid = 1'b1; reqAddr = 3;
        #1;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL basic_reqReady: got %b expected 1", reqReady); end
        @(posedge clock);
        #1 reqValid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_resp(20, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        checks++; if (respInstr !== 32'h2008_0005) begin errors++; $display("FAIL basic_instr: got %08h expected 20080005", respInstr); end
        checks++; if (respAddr !== 32'd3) begin errors++; $display("FAIL basic_addr: got %0d expected 3", respAddr); end
        checks++; if (respErr !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", respErr); end
        $display("req addr=3 lat=%0d instr=%08h err=%b", lat, respInstr, respErr);
        @(negedge clock);
        checks++; if (respValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_return_idle: respValid %b busy %b expected 0 0", respValid, busy); end
    endtask

    task automatic test_stall;
        int lat;
        respReady = 1'b0;
        send_req(5);
        wait_resp(20, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL stall_latency: got %0d expected 2", lat); end
        reqValid = 1'b1;
        reqAddr  = 9;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++; if (respValid !== 1'b1) begin errors++; $display("FAIL stall_respValid cyc %0d: got %b expected 1", c, respValid); end
            checks++; if (respInstr !== 32'hC0DE_0005 || respAddr !== 32'd5) begin errors++; $display("FAIL stall_hold cyc %0d: got %08h@%0d expected c0de0005@5", c, respInstr, respAddr); end
            checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL stall_reqReady cyc %0d: got %b expected 0", c, reqReady); end
        end
        $display("stall addr=5 held 5 cycles instr=%08h", respInstr);
        respReady = 1'b1;
        @(negedge clock);
        checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL stall_release: respValid got %b expected 0", respValid); end
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL stall_next_ready: got %b expected 1", reqReady); end
        @(posedge clock);
        #1 reqValid = 1'b0;
        wait_resp(20, lat);
        checks++; if (lat !== 2 || respInstr !== 32'hC0DE_0009 || respAddr !== 32'd9) begin errors++; $display("FAIL stall_next_req: got lat %0d %08h@%0d expected lat 2 c0de0009@9", lat, respInstr, respAddr); end
        $display("req addr=9 lat=%0d instr=%08h", lat, respInstr);
    endtask

    task automatic test_out_of_range;
        int lat;
        send_req(300);
        wait_resp(20, lat);
        checks++; if (lat !== 2 || respInstr !== 32'h0 || respErr !== 1'b1 || respAddr !== 32'd300) begin errors++; $display("FAIL oor_300: got lat %0d instr %08h err %b addr %0d expected 2 00000000 1 300", lat, respInstr, respErr, respAddr); end
        $display("req addr=300 instr=%08h err=%b", respInstr, respErr);
        send_req(32'h8000_0003);
        wait_resp(20, lat);
        checks++; if (respInstr !== 32'h0 || respErr !== 1'b1) begin errors++; $display("FAIL oor_high_bit: got instr %08h err %b expected 00000000 1", respInstr, respErr); end
        $display("req addr=80000003 instr=%08h err=%b", respInstr, respErr);
        send_req(255);
        wait_resp(20, lat);
        checks++; if (respInstr !== 32'hFF00_00FF || respErr !== 1'b0) begin errors++; $display("FAIL oor_255: got instr %08h err %b expected ff0000ff 0", respInstr, respErr); end
        $display("req addr=255 instr=%08h err=%b", respInstr, respErr);
        send_req(256);
        wait_resp(20, lat);
        checks++; if (respInstr !== 32'h0 || respErr !== 1'b1) begin errors++; $display("FAIL oor_256: got instr %08h err %b expected 00000000 1", respInstr, respErr); end
        $display("req addr=256 instr=%08h err=%b", respInstr, respErr);
        @(negedge clock);
        loadEn = 1'b1; loadAddr = 300; loadData = 32'hDEAD_BEEF;
        @(negedge clock);
        loadEn = 1'b0;
        checks++; if (busy !== 1'b0 || respValid !== 1'b0) begin errors++; $display("FAIL oor_load_side_effect: busy %b respValid %b expected 0 0", busy, respValid); end
        send_req(44);
        wait_resp(20, lat);
        checks++; if (respInstr !== 32'h4444_4444 || respErr !== 1'b0) begin errors++; $display("FAIL oor_load_wrap: got instr %08h err %b expected 44444444 0", respInstr, respErr); end
        $display("req addr=44 instr=%08h err=%b", respInstr, respErr);
    endtask

    task automatic test_flush;
        int lat;
        logic seen;
        send_req(10);
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_wait_idle: busy got %b expected 0", busy); end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (respValid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_resp: respValid seen %b expected 0", seen); end
        $display("flush dropped addr=10");
        @(negedge clock);
        flush = 1'b1; reqValid = 1'b1; reqAddr = 8;
        #1;
        checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL flush_beats_req: reqReady got %b expected 0", reqReady); end
        @(negedge clock);
        flush = 1'b0; reqValid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_req_not_taken: busy got %b expected 0", busy); end
        respReady = 1'b0;
        send_req(6);
        wait_resp(20, lat);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        respReady = 1'b1;
        checks++; if (respValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_in_resp: respValid %b busy %b expected 0 0", respValid, busy); end
        $display("flush dropped held addr=6");
        send_req(7);
        wait_resp(20, lat);
        checks++; if (lat !== 2 || respInstr !== 32'hC0DE_0007 || respAddr !== 32'd7) begin errors++; $display("FAIL flush_then_req7: got lat %0d %08h@%0d expected lat 2 c0de0007@7", lat, respInstr, respAddr); end
        $display("req addr=7 lat=%0d instr=%08h", lat, respInstr);
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen;
        send_req(3);
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (respValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state: respValid %b busy %b expected 0 0", respValid, busy); end
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (respValid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp: respValid seen %b expected 0", seen); end
        send_req(3);
        wait_resp(20, lat);
        checks++; if (lat !== 2 || respInstr !== 32'h2008_0005) begin errors++; $display("FAIL rst_mid_store_kept: got lat %0d %08h expected lat 2 20080005", lat, respInstr); end
        $display("req addr=3 after reset lat=%0d instr=%08h", lat, respInstr);
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_latency_sweep();
        test_basic();
        test_stall();
        test_out_of_range();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
